// File: rtl/tpu_tiled_core_if.sv
// ----------------------------------------------------------------------------
// tpu_tiled_core_if
// Purpose : bundles the job-control handshake and the A/B/C global buffer
//           ports of the tiled systolic matrix engine.
// Signals : in_valid, K, M, N        job start pulse and matrix dimensions
//           busy, ap_done, ap_idle   job status
//           A_wr_en/A_index/A_data_out  A buffer (read-only, 1-cycle latency)
//           B_wr_en/B_index/B_data_out  B buffer (read-only, 1-cycle latency)
//           C_wr_en/C_index/C_data_in   C buffer row write port
// Modports: master = engine side, slave = buffers / job controller side.
// ----------------------------------------------------------------------------
interface tpu_tiled_core_if #(
    parameter int P      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int IDX_W  = 16
) ();
    logic                  in_valid;
    logic [7:0]            K;
    logic [7:0]            M;
    logic [7:0]            N;
    logic                  busy;
    logic                  ap_done;
    logic                  ap_idle;
    logic                  A_wr_en;
    logic [IDX_W-1:0]      A_index;
    logic [P*DATA_W-1:0]   A_data_out;
    logic                  B_wr_en;
    logic [IDX_W-1:0]      B_index;
    logic [P*DATA_W-1:0]   B_data_out;
    logic                  C_wr_en;
    logic [IDX_W-1:0]      C_index;
    logic [P*ACC_W-1:0]    C_data_in;

    modport master (
        input  in_valid, K, M, N, A_data_out, B_data_out,
        output busy, ap_done, ap_idle,
        output A_wr_en, A_index, B_wr_en, B_index,
        output C_wr_en, C_index, C_data_in
    );

    modport slave (
        output in_valid, K, M, N, A_data_out, B_data_out,
        input  busy, ap_done, ap_idle,
        input  A_wr_en, A_index, B_wr_en, B_index,
        input  C_wr_en, C_index, C_data_in
    );
endinterface

// File: rtl/tpu_tiled_core.sv
// ----------------------------------------------------------------------------
// tpu_tiled_core
// Purpose : P x P output-stationary systolic engine with a built-in tile
//           sequencer computing C[MxN] = A[MxK] * B[KxN]. Output tiles are
//           walked row-major; each tile streams K operand words (FEED), lets
//           the array settle (DRAIN, 2P-1 cycles) and writes P C rows (WRITE).
// Ports   : clk     rising-edge clock
//           rst_n   asynchronous active-low reset
//           io_bus  tpu_tiled_core_if.master (handshake + A/B/C buffers)
// Config  : TPU_SIGNED_EN defined   -> A/B lanes are two's complement
//           TPU_SIGNED_EN undefined -> A/B lanes are unsigned
// ----------------------------------------------------------------------------
module tpu_tiled_core #(
    parameter int P      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int IDX_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tpu_tiled_core_if.master     io_bus
);
    localparam int         RW         = (P > 1) ? $clog2(P) : 1;
    localparam logic [7:0] DRAIN_LAST = 8'(2*P-2);
    localparam logic [7:0] ROW_LAST   = 8'(P-1);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t             r_state;
    logic [7:0]         r_k, r_m, r_n, r_mbLast, r_nbLast, r_mb, r_nb, r_cnt;
    logic               r_zero, r_feedD, r_done, r_cWrEn;
    logic [IDX_W-1:0]   r_aIdx, r_bIdx, r_cIdx, r_aBase, r_bBase, r_cBase, r_m0, r_n0;

    logic [8:0]         w_mbNum, w_nbNum;
    logic               w_zeroDim, w_clear;
    logic [DATA_W-1:0]  w_aIn [P][P];
    logic [DATA_W-1:0]  w_bIn [P][P];
    logic [ACC_W-1:0]   w_acc [P][P];

    assign w_mbNum   = ({1'b0, io_bus.M} + 9'(P-1)) / 9'(P);
    assign w_nbNum   = ({1'b0, io_bus.N} + 9'(P-1)) / 9'(P);
    assign w_zeroDim = (io_bus.K == 8'd0) || (io_bus.M == 8'd0) || (io_bus.N == 8'd0);
    assign w_clear   = (r_state == S_FEED) && (r_cnt == 8'd0);

    assign io_bus.busy    = (r_state != S_IDLE);
    assign io_bus.ap_idle = (r_state == S_IDLE);
    assign io_bus.ap_done = r_done;
    assign io_bus.A_wr_en = 1'b0;
    assign io_bus.B_wr_en = 1'b0;
    assign io_bus.A_index = r_aIdx;
    assign io_bus.B_index = r_bIdx;
    assign io_bus.C_wr_en = r_cWrEn;
    assign io_bus.C_index = r_cIdx;

    // Tile sequencer. Index registers are loaded one edge ahead so each FEED
    // cycle already presents its own A/B address. A zero-sized job still
    // spends one FEED cycle (no address movement) before DONE, giving a fixed
    // two-cycle accept-to-done latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_mbLast <= '0;
            r_nbLast <= '0;
            r_mb     <= '0;
            r_nb     <= '0;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_feedD  <= 1'b0;
            r_done   <= 1'b0;
            r_cWrEn  <= 1'b0;
            r_aIdx   <= '0;
            r_bIdx   <= '0;
            r_cIdx   <= '0;
            r_aBase  <= '0;
            r_bBase  <= '0;
            r_cBase  <= '0;
            r_m0     <= '0;
            r_n0     <= '0;
        end else begin
            r_feedD <= (r_state == S_FEED) && !r_zero;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_k      <= io_bus.K;
                        r_m      <= io_bus.M;
                        r_n      <= io_bus.N;
                        r_mbLast <= 8'(w_mbNum - 9'd1);
                        r_nbLast <= 8'(w_nbNum - 9'd1);
                        r_mb     <= '0;
                        r_nb     <= '0;
                        r_cnt    <= '0;
                        r_m0     <= '0;
                        r_n0     <= '0;
                        r_aBase  <= '0;
                        r_bBase  <= '0;
                        r_cBase  <= '0;
                        r_zero   <= w_zeroDim;
                        if (!w_zeroDim) begin
                            r_aIdx <= '0;
                            r_bIdx <= '0;
                        end
                        r_state  <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (r_zero) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == r_k - 8'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_aIdx <= r_aIdx + IDX_W'(1);
                        r_bIdx <= r_bIdx + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        r_cnt   <= '0;
                        r_cWrEn <= 1'b1;
                        r_cIdx  <= r_cBase;
                        r_state <= S_WRITE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == ROW_LAST) begin
                        r_cnt   <= '0;
                        r_cWrEn <= 1'b0;
                        r_cBase <= r_cBase + IDX_W'(P);
                        if (r_nb == r_nbLast) begin
                            if (r_mb == r_mbLast) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_nb    <= '0;
                                r_n0    <= '0;
                                r_bBase <= '0;
                                r_bIdx  <= '0;
                                r_mb    <= r_mb + 8'd1;
                                r_m0    <= r_m0 + IDX_W'(P);
                                r_aBase <= r_aBase + IDX_W'(r_k);
                                r_aIdx  <= r_aBase + IDX_W'(r_k);
                                r_state <= S_FEED;
                            end
                        end else begin
                            r_nb    <= r_nb + 8'd1;
                            r_n0    <= r_n0 + IDX_W'(P);
                            r_bBase <= r_bBase + IDX_W'(r_k);
                            r_bIdx  <= r_bBase + IDX_W'(r_k);
                            r_aIdx  <= r_aBase;
                            r_state <= S_FEED;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_cIdx  <= r_cIdx + IDX_W'(1);
                        // rows beyond M are skipped but still take their slot
                        r_cWrEn <= (r_m0 + IDX_W'(r_cnt) + IDX_W'(1)) < IDX_W'(r_m);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Input skew: lane i of A enters PE row i delayed i cycles (B likewise
    // per column). Lanes outside the matrix or outside the data window
    // inject zeros so partial tiles and idle cycles add nothing.
    for (genvar i = 0; i < P; i++) begin : g_skew
        logic [DATA_W-1:0] w_aRaw, w_bRaw;
        assign w_aRaw = (r_feedD && ((r_m0 + IDX_W'(i)) < IDX_W'(r_m)))
                        ? io_bus.A_data_out[i*DATA_W +: DATA_W] : '0;
        assign w_bRaw = (r_feedD && ((r_n0 + IDX_W'(i)) < IDX_W'(r_n)))
                        ? io_bus.B_data_out[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign w_aIn[0][0] = w_aRaw;
            assign w_bIn[0][0] = w_bRaw;
        end else begin : g_line
            logic [DATA_W-1:0] r_aLine [i];
            logic [DATA_W-1:0] r_bLine [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < i; d++) begin
                        r_aLine[d] <= '0;
                        r_bLine[d] <= '0;
                    end
                end else begin
                    r_aLine[0] <= w_aRaw;
                    r_bLine[0] <= w_bRaw;
                    for (int d = 1; d < i; d++) begin
                        r_aLine[d] <= r_aLine[d-1];
                        r_bLine[d] <= r_bLine[d-1];
                    end
                end
            end
            assign w_aIn[i][0] = r_aLine[i-1];
            assign w_bIn[0][i] = r_bLine[i-1];
        end
    end

    // PE array: operands hop east/south one register per PE; each PE holds
    // its own output-stationary accumulator, cleared on the first FEED cycle.
    for (genvar i = 0; i < P; i++) begin : g_row
        for (genvar j = 0; j < P; j++) begin : g_pe
            logic [ACC_W-1:0]    r_acc;
            logic [2*DATA_W-1:0] w_prod;
            logic [ACC_W-1:0]    w_prodExt;
`ifdef TPU_SIGNED_EN
            logic signed [2*DATA_W-1:0] w_sProd;
            assign w_sProd   = $signed({{DATA_W{w_aIn[i][j][DATA_W-1]}}, w_aIn[i][j]})
                             * $signed({{DATA_W{w_bIn[i][j][DATA_W-1]}}, w_bIn[i][j]});
            assign w_prod    = w_sProd;
            assign w_prodExt = ACC_W'(w_sProd);
`else
            assign w_prod    = {{DATA_W{1'b0}}, w_aIn[i][j]} * {{DATA_W{1'b0}}, w_bIn[i][j]};
            assign w_prodExt = ACC_W'(w_prod);
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       r_acc <= '0;
                else if (w_clear) r_acc <= '0;
                else              r_acc <= r_acc + w_prodExt;
            end
            assign w_acc[i][j] = r_acc;

            if (j < P-1) begin : g_east
                logic [DATA_W-1:0] r_a;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_a <= '0;
                    else        r_a <= w_aIn[i][j];
                end
                assign w_aIn[i][j+1] = r_a;
            end
            if (i < P-1) begin : g_south
                logic [DATA_W-1:0] r_b;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) r_b <= '0;
                    else        r_b <= w_bIn[i][j];
                end
                assign w_bIn[i+1][j] = r_b;
            end
        end
    end

    // C row is read straight from the accumulators: the last products land
    // on the edge that enters WRITE, so a registered copy would be a cycle
    // late. Columns beyond N read as zero.
    for (genvar j = 0; j < P; j++) begin : g_cOut
        assign io_bus.C_data_in[j*ACC_W +: ACC_W] =
            (r_cWrEn && ((r_n0 + IDX_W'(j)) < IDX_W'(r_n))) ? w_acc[r_cnt[RW-1:0]][j] : '0;
    end
endmodule
